csr_access_ctrl: RTL and testbench
==================================

CSR_ACCESS_CTRL -- requirements
Module: csr_access_ctrl

Interface
REQ-001 SHALL have parameter RD_TIMEOUT, default 15, meaning max cycles waiting for CSR_RVALID before an error response.
REQ-002 SHALL have port CLK  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port RST_N  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port FLUSH  input  1  pipeline flush; aborts instruction-side access.
REQ-005 SHALL have ports I_REQ in 1, I_OP in 2 (01=RW, 10=RS, 11=RC), I_ADDR in 12, I_WDATA in 32  instruction-side request.
REQ-006 SHALL have ports I_ACK out 1, I_RDATA out 32, I_ERR out 1  instruction-side response.
REQ-007 SHALL have ports T_REQ in 1, T_ADDR in 12, T_WDATA in 32  trap-unit request; always a plain write (RW).
REQ-008 SHALL have ports T_ACK out 1, T_RDATA out 32  trap-unit response.
REQ-009 SHALL have ports CSR_RADDR out 12, CSR_RVALID in 1, CSR_RDATA in 32  CSR file read port.
REQ-010 SHALL have ports CSR_WREN out 1, CSR_WADDR out 12, CSR_WDATA out 32  CSR file write port.
REQ-011 SHALL have port BUSY  output  1  high in any state except IDLE.

Function
REQ-012 SHALL implement FSM states IDLE, READ, WRITE, RESP.
REQ-013 IDLE: on T_REQ, latch trap request (T has priority); else on I_REQ with I_OP!=00, latch instruction request; then go to READ.
REQ-014 I_OP=00 with I_REQ in IDLE SHALL be ignored (no ack, no state change).
REQ-015 READ: drive CSR_RADDR=latched addr; stay until CSR_RVALID=1, then capture CSR_RDATA as old value and go to WRITE.
REQ-016 READ SHALL count cycles; on count reaching RD_TIMEOUT without CSR_RVALID, go to RESP with error flag set and no write.
REQ-017 WRITE: new = operand (RW), old|operand (RS), old&~operand (RC); assert CSR_WREN for exactly one cycle with CSR_WADDR/CSR_WDATA; go to RESP.
REQ-018 RS/RC with operand 0 SHALL skip the write (CSR_WREN stays 0) but still pass through WRITE.
REQ-019 RESP: pulse the owning requester's ACK for exactly one cycle; RDATA = old value (0 on error); I_ERR=error flag; return to IDLE.
REQ-020 Latency, no timeout, RVALID at first READ cycle: request accepted cycle N, write at N+2, ACK at N+3.
REQ-021 Requester SHALL hold REQ until ACK; a REQ still high in the IDLE cycle after ACK is a new request.
REQ-022 FLUSH while owning an instruction request in READ or WRITE SHALL return to IDLE next cycle with no CSR_WREN and no I_ACK; FLUSH in RESP SHALL suppress I_ACK.
REQ-023 FLUSH SHALL NOT affect a trap-owned access.
REQ-024 Simultaneous T_REQ and I_REQ in IDLE: trap served first; instruction served after trap's RESP.
REQ-025 CSR_RADDR SHALL be 0 outside READ; CSR_WADDR/CSR_WDATA SHALL be 0 when CSR_WREN=0.

Reset
REQ-026 RST_N low SHALL force IDLE, timeout counter 0, all latched data 0, every output 0, asynchronously.
REQ-027 Reset mid-access SHALL drop it without write or ack; deassertion is synchronised by the integrating top.

Structure
REQ-028 Op encodings (RW/RS/RC) and FSM state encodings SHALL live in a shared package csr_pkg.
REQ-029 Modify logic (REQ-017/018) SHALL be a combinational sub-module csr_alu; FSM and counter remain in this module.

Verification
REQ-030 I RW addr 0x300 wdata 0xDEADBEEF, RVALID immediate, old 0x00001800 -> WREN at N+2 data 0xDEADBEEF; I_ACK at N+3 RDATA 0x00001800.
REQ-031 I RS addr 0x304 wdata 0x00000088, old 0x00000800 -> WDATA 0x00000888; RC same operand, old 0x00000888 -> WDATA 0x00000800.
REQ-032 I RS wdata 0 -> no WREN; I_ACK with RDATA=old.
REQ-033 T_REQ addr 0x341 and I_REQ same cycle -> trap write/T_ACK first; I access completes after.
REQ-034 CSR_RVALID held 0 -> after 15 READ cycles I_ACK with I_ERR=1, RDATA 0, no WREN.
REQ-035 FLUSH in WRITE of I access -> no WREN, no I_ACK, IDLE next cycle; RST_N low mid-READ -> all outputs 0 immediately.

Source files
------------

// File: rtl/csr_pkg.sv
// Shared encodings for the CSR access controller: operation codes, FSM states
// and the CSR address/data widths.
package csr_pkg;

  localparam int CSR_AW = 12;
  localparam int CSR_DW = 32;

  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_RW   = 2'b01,
    OP_RS   = 2'b10,
    OP_RC   = 2'b11
  } csr_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READ  = 2'b01,
    ST_WRITE = 2'b10,
    ST_RESP  = 2'b11
  } csr_state_e;

endpackage

// File: rtl/csr_alu.sv
// Read-modify-write datapath: computes the new CSR value and whether the
// write is needed at all (set/clear with an all-zero mask leaves the CSR alone).
module csr_alu
  import csr_pkg::*;
(
  input  csr_op_e           op,
  input  logic [CSR_DW-1:0] old_val,
  input  logic [CSR_DW-1:0] operand,
  output logic [CSR_DW-1:0] new_val,
  output logic              wr_en
);

  // Modify function selected by the latched operation
  always_comb begin
    new_val = old_val;
    wr_en   = 1'b0;
    case (op)
      OP_RW: begin
        new_val = operand;
        wr_en   = 1'b1;
      end
      OP_RS: begin
        new_val = old_val | operand;
        wr_en   = (operand != {CSR_DW{1'b0}});
      end
      OP_RC: begin
        new_val = old_val & ~operand;
        wr_en   = (operand != {CSR_DW{1'b0}});
      end
      default: begin
        new_val = old_val;
        wr_en   = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/csr_access_ctrl.sv
// Arbitrates trap-unit and instruction-side CSR accesses and sequences each one
// as read / modify-write / respond against the CSR file, with a read timeout.
module csr_access_ctrl
  import csr_pkg::*;
#(
  parameter int RD_TIMEOUT = 15
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              FLUSH,
  input  logic              I_REQ,
  input  logic [1:0]        I_OP,
  input  logic [CSR_AW-1:0] I_ADDR,
  input  logic [CSR_DW-1:0] I_WDATA,
  output logic              I_ACK,
  output logic [CSR_DW-1:0] I_RDATA,
  output logic              I_ERR,
  input  logic              T_REQ,
  input  logic [CSR_AW-1:0] T_ADDR,
  input  logic [CSR_DW-1:0] T_WDATA,
  output logic              T_ACK,
  output logic [CSR_DW-1:0] T_RDATA,
  output logic [CSR_AW-1:0] CSR_RADDR,
  input  logic              CSR_RVALID,
  input  logic [CSR_DW-1:0] CSR_RDATA,
  output logic              CSR_WREN,
  output logic [CSR_AW-1:0] CSR_WADDR,
  output logic [CSR_DW-1:0] CSR_WDATA,
  output logic              BUSY
);

  localparam int CNT_W = (RD_TIMEOUT < 2) ? 1 : $clog2(RD_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_TIMEOUT - 1);

  csr_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  csr_op_e           op_q, op_d;
  logic [CSR_AW-1:0] addr_q, addr_d;
  logic [CSR_DW-1:0] operand_q, operand_d;
  logic [CSR_DW-1:0] old_q, old_d;
  logic              trap_q, trap_d;
  logic              err_q, err_d;

  logic [CSR_DW-1:0] new_val_s;
  logic              alu_we_s;
  logic              flush_abort_s;
  logic [CSR_DW-1:0] rdata_s;

  csr_alu u_alu (
    .op      (op_q),
    .old_val (old_q),
    .operand (operand_q),
    .new_val (new_val_s),
    .wr_en   (alu_we_s)
  );

  // A flush only ever cancels work owned by the instruction side
  assign flush_abort_s = FLUSH & ~trap_q;

  // Next-state and latch logic for the access sequencer
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    addr_d    = addr_q;
    operand_d = operand_q;
    old_d     = old_q;
    trap_d    = trap_q;
    err_d     = err_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = {CNT_W{1'b0}};
        err_d = 1'b0;
        if (T_REQ) begin
          trap_d    = 1'b1;
          op_d      = OP_RW;
          addr_d    = T_ADDR;
          operand_d = T_WDATA;
          old_d     = {CSR_DW{1'b0}};
          state_d   = ST_READ;
        end else if (I_REQ && (I_OP != 2'b00)) begin
          trap_d    = 1'b0;
          op_d      = csr_op_e'(I_OP);
          addr_d    = I_ADDR;
          operand_d = I_WDATA;
          old_d     = {CSR_DW{1'b0}};
          state_d   = ST_READ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_READ: begin
        if (flush_abort_s) begin
          state_d = ST_IDLE;
        end else if (CSR_RVALID) begin
          old_d   = CSR_RDATA;
          state_d = ST_WRITE;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_WRITE: begin
        if (flush_abort_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and latched-request registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= ST_IDLE;
      cnt_q     <= {CNT_W{1'b0}};
      op_q      <= OP_NONE;
      addr_q    <= {CSR_AW{1'b0}};
      operand_q <= {CSR_DW{1'b0}};
      old_q     <= {CSR_DW{1'b0}};
      trap_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      addr_q    <= addr_d;
      operand_q <= operand_d;
      old_q     <= old_d;
      trap_q    <= trap_d;
      err_q     <= err_d;
    end
  end

  // Outputs decode registered state; FLUSH gates the write and ack in-cycle
  assign BUSY      = (state_q != ST_IDLE);
  assign CSR_RADDR = (state_q == ST_READ) ? addr_q : {CSR_AW{1'b0}};
  assign CSR_WREN  = (state_q == ST_WRITE) & alu_we_s & ~flush_abort_s;
  assign CSR_WADDR = CSR_WREN ? addr_q : {CSR_AW{1'b0}};
  assign CSR_WDATA = CSR_WREN ? new_val_s : {CSR_DW{1'b0}};
  assign rdata_s   = err_q ? {CSR_DW{1'b0}} : old_q;
  assign I_ACK     = (state_q == ST_RESP) & ~trap_q & ~FLUSH;
  assign I_RDATA   = I_ACK ? rdata_s : {CSR_DW{1'b0}};
  assign I_ERR     = I_ACK & err_q;
  assign T_ACK     = (state_q == ST_RESP) & trap_q;
  assign T_RDATA   = T_ACK ? rdata_s : {CSR_DW{1'b0}};

endmodule

// File: tb/tb_csr_access_ctrl.sv
// Bench for csr_access_ctrl: directed vector table, hand-written arbitration and
// reset sequences, then random accesses checked against a CSR-memory model.
module tb_csr_access_ctrl;

  localparam int TO = 15;

  logic        CLK, RST_N, FLUSH;
  logic        I_REQ;
  logic [1:0]  I_OP;
  logic [11:0] I_ADDR;
  logic [31:0] I_WDATA;
  logic        I_ACK;
  logic [31:0] I_RDATA;
  logic        I_ERR;
  logic        T_REQ;
  logic [11:0] T_ADDR;
  logic [31:0] T_WDATA;
  logic        T_ACK;
  logic [31:0] T_RDATA;
  logic [11:0] CSR_RADDR;
  logic        CSR_RVALID;
  logic [31:0] CSR_RDATA;
  logic        CSR_WREN;
  logic [11:0] CSR_WADDR;
  logic [31:0] CSR_WDATA;
  logic        BUSY;

  csr_access_ctrl #(.RD_TIMEOUT(TO)) dut (
    .CLK(CLK), .RST_N(RST_N), .FLUSH(FLUSH),
    .I_REQ(I_REQ), .I_OP(I_OP), .I_ADDR(I_ADDR), .I_WDATA(I_WDATA),
    .I_ACK(I_ACK), .I_RDATA(I_RDATA), .I_ERR(I_ERR),
    .T_REQ(T_REQ), .T_ADDR(T_ADDR), .T_WDATA(T_WDATA),
    .T_ACK(T_ACK), .T_RDATA(T_RDATA),
    .CSR_RADDR(CSR_RADDR), .CSR_RVALID(CSR_RVALID), .CSR_RDATA(CSR_RDATA),
    .CSR_WREN(CSR_WREN), .CSR_WADDR(CSR_WADDR), .CSR_WDATA(CSR_WDATA),
    .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int          c;
    logic [31:0] a;
    logic [31:0] d;
    logic        e;
  } ev_t;

  typedef struct {
    logic        is_trap;
    logic [1:0]  op;
    logic [11:0] addr;
    logic [31:0] wd;
    logic [31:0] old;
    int          delay;
    int          flush_off;
    logic        exp_we;
    logic [31:0] exp_wd;
    logic        exp_ack;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_lat;
    logic        preload;
  } vec_t;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int rd_cnt = 0;
  int rv_delay = 0;
  int flush_at = -1;
  int zero_viol = 0;

  logic        i_pend = 1'b0;
  logic [1:0]  i_op = 2'b00;
  logic [11:0] i_addr = 12'h000;
  logic [31:0] i_wd = 32'h0;
  logic        t_pend = 1'b0;
  logic [11:0] t_addr = 12'h000;
  logic [31:0] t_wd = 32'h0;

  logic [31:0] csr_mem [0:4095];
  logic [31:0] ref_mem [0:4095];
  bit          busy_log [int];
  ev_t         wr_q [$];
  ev_t         iack_q [$];
  ev_t         tack_q [$];
  vec_t        tbl [13];

  logic [127:0] outs_s;
  assign outs_s = {3'b000, I_ACK, I_RDATA, I_ERR, T_ACK, T_RDATA, CSR_RADDR,
                   CSR_WREN, CSR_WADDR, CSR_WDATA, BUSY};

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One clock cycle: act as the CSR file and requesters, then log what the DUT did
  task automatic step();
    ev_t ev;
    @(negedge CLK);
    if (CSR_RADDR != 12'h000) begin
      CSR_RVALID = (rd_cnt == rv_delay);
      CSR_RDATA  = CSR_RVALID ? csr_mem[CSR_RADDR] : $urandom;
      rd_cnt++;
    end else begin
      rd_cnt     = 0;
      CSR_RVALID = 1'b0;
      CSR_RDATA  = $urandom;
    end
    FLUSH = (cyc == flush_at);
    if (FLUSH) i_pend = 1'b0;
    I_REQ = i_pend; I_OP = i_op; I_ADDR = i_addr; I_WDATA = i_wd;
    T_REQ = t_pend; T_ADDR = t_addr; T_WDATA = t_wd;
    #1;
    busy_log[cyc] = BUSY;
    if (CSR_WREN) begin
      ev.c = cyc; ev.a = 32'(CSR_WADDR); ev.d = CSR_WDATA; ev.e = 1'b0;
      wr_q.push_back(ev);
      csr_mem[CSR_WADDR] = CSR_WDATA;
    end else if ((CSR_WADDR != 12'h000) || (CSR_WDATA != 32'h0)) begin
      zero_viol++;
    end
    if (I_ACK) begin
      ev.c = cyc; ev.a = 32'h0; ev.d = I_RDATA; ev.e = I_ERR;
      iack_q.push_back(ev);
      i_pend = 1'b0;
    end
    if (T_ACK) begin
      ev.c = cyc; ev.a = 32'h0; ev.d = T_RDATA; ev.e = 1'b0;
      tack_q.push_back(ev);
      t_pend = 1'b0;
    end
    cyc++;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  // Reference: expected outcome of one access from the CSR memory model
  function automatic vec_t model(input logic is_trap, input logic [1:0] op,
                                 input logic [11:0] addr, input logic [31:0] wd,
                                 input int delay, input int flush_off);
    vec_t v;
    logic [31:0] old, nv;
    logic ok, aborted, writes;
    old = ref_mem[addr];
    ok  = (delay < TO);
    v.is_trap = is_trap; v.op = op; v.addr = addr; v.wd = wd; v.old = old;
    v.delay = delay; v.flush_off = flush_off; v.preload = 1'b0;
    v.exp_lat = ok ? delay + 3 : TO + 1;
    case (op)
      2'b01:   nv = wd;
      2'b10:   nv = old | wd;
      2'b11:   nv = old & ~wd;
      default: nv = old;
    endcase
    writes    = ok && ((op == 2'b01) || (wd != 32'h0));
    aborted   = !is_trap && (flush_off >= 1) && (flush_off < v.exp_lat);
    v.exp_we  = writes && !aborted;
    v.exp_wd  = v.exp_we ? nv : 32'h0;
    v.exp_ack = !aborted && (is_trap || (flush_off != v.exp_lat));
    v.exp_rd  = ok ? old : 32'h0;
    v.exp_err = !ok && !is_trap;
    return v;
  endfunction

  task automatic check_access(input int idx, input vec_t v);
    int n;
    string p;
    p = $sformatf("v%0d", idx);
    if (v.preload) begin
      csr_mem[v.addr] = v.old;
      ref_mem[v.addr] = v.old;
    end
    wr_q.delete(); iack_q.delete(); tack_q.delete();
    n = cyc;
    rv_delay = v.delay;
    flush_at = (v.flush_off > 0) ? n + v.flush_off : -1;
    if (v.is_trap) begin
      t_pend = 1'b1; t_addr = v.addr; t_wd = v.wd;
    end else begin
      i_pend = 1'b1; i_op = v.op; i_addr = v.addr; i_wd = v.wd;
    end
    run(24);
    i_pend = 1'b0; t_pend = 1'b0; flush_at = -1;
    chk({p, "_wr_cnt"}, 128'(wr_q.size()), 128'(v.exp_we));
    if (v.exp_we && (wr_q.size() > 0)) begin
      chk({p, "_wr_cyc"}, 128'(wr_q[0].c - n), 128'(v.exp_lat - 1));
      chk({p, "_wr_addr"}, 128'(wr_q[0].a), 128'(v.addr));
      chk({p, "_wr_data"}, 128'(wr_q[0].d), 128'(v.exp_wd));
    end
    if (v.is_trap) begin
      chk({p, "_tack_cnt"}, 128'(tack_q.size()), 128'(v.exp_ack));
      chk({p, "_stray_iack"}, 128'(iack_q.size()), 128'(0));
      if (v.exp_ack && (tack_q.size() > 0)) begin
        chk({p, "_tack_cyc"}, 128'(tack_q[0].c - n), 128'(v.exp_lat));
        chk({p, "_trdata"}, 128'(tack_q[0].d), 128'(v.exp_rd));
      end
    end else begin
      chk({p, "_iack_cnt"}, 128'(iack_q.size()), 128'(v.exp_ack));
      chk({p, "_stray_tack"}, 128'(tack_q.size()), 128'(0));
      if (v.exp_ack && (iack_q.size() > 0)) begin
        chk({p, "_iack_cyc"}, 128'(iack_q[0].c - n), 128'(v.exp_lat));
        chk({p, "_irdata"}, 128'(iack_q[0].d), 128'(v.exp_rd));
        chk({p, "_ierr"}, 128'(iack_q[0].e), 128'(v.exp_err));
      end
      if (v.flush_off > 0)
        chk({p, "_idle_after_flush"}, 128'(busy_log[n + v.flush_off + 1]), 128'(0));
    end
    chk({p, "_idle_end"}, 128'(busy_log[cyc - 1]), 128'(0));
    if (v.exp_we) ref_mem[v.addr] = v.exp_wd;
  endtask

  initial begin
    int n;
    int r;
    logic        busy_any;
    logic        rt;
    logic [1:0]  rop;
    logic [11:0] raddr;
    logic [31:0] rwd, old_t, old_i;
    int          rdly, rfl, rlat;
    vec_t        v;

    CLK = 1'b0; RST_N = 1'b0; FLUSH = 1'b0;
    I_REQ = 1'b0; I_OP = 2'b00; I_ADDR = 12'h000; I_WDATA = 32'h0;
    T_REQ = 1'b0; T_ADDR = 12'h000; T_WDATA = 32'h0;
    CSR_RVALID = 1'b0; CSR_RDATA = 32'h0;
    for (int i = 0; i < 4096; i++) begin
      csr_mem[i] = $urandom;
      ref_mem[i] = csr_mem[i];
    end

    #12;
    chk("reset_outputs", outs_s, 128'(0));
    @(negedge CLK);
    RST_N = 1'b1;
    run(2);
    chk("idle_after_reset", 128'(BUSY), 128'(0));

    tbl[0]  = '{1'b0, 2'b01, 12'h300, 32'hDEADBEEF, 32'h00001800, 0,  -1, 1'b1, 32'hDEADBEEF, 1'b1, 32'h00001800, 1'b0, 3,  1'b1};
    tbl[1]  = '{1'b0, 2'b10, 12'h304, 32'h00000088, 32'h00000800, 0,  -1, 1'b1, 32'h00000888, 1'b1, 32'h00000800, 1'b0, 3,  1'b1};
    tbl[2]  = '{1'b0, 2'b11, 12'h304, 32'h00000088, 32'h00000888, 0,  -1, 1'b1, 32'h00000800, 1'b1, 32'h00000888, 1'b0, 3,  1'b1};
    tbl[3]  = '{1'b0, 2'b10, 12'h305, 32'h00000000, 32'h12345678, 0,  -1, 1'b0, 32'h00000000, 1'b1, 32'h12345678, 1'b0, 3,  1'b1};
    tbl[4]  = '{1'b0, 2'b11, 12'h306, 32'h00000000, 32'hCAFEF00D, 0,  -1, 1'b0, 32'h00000000, 1'b1, 32'hCAFEF00D, 1'b0, 3,  1'b1};
    tbl[5]  = '{1'b0, 2'b01, 12'h307, 32'h00000000, 32'h0000AAAA, 0,  -1, 1'b1, 32'h00000000, 1'b1, 32'h0000AAAA, 1'b0, 3,  1'b1};
    tbl[6]  = '{1'b0, 2'b01, 12'h308, 32'h11111111, 32'h55555555, 99, -1, 1'b0, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 16, 1'b1};
    tbl[7]  = '{1'b0, 2'b10, 12'h309, 32'h000000F0, 32'h0000000F, 14, -1, 1'b1, 32'h000000FF, 1'b1, 32'h0000000F, 1'b0, 17, 1'b1};
    tbl[8]  = '{1'b0, 2'b01, 12'h30A, 32'h00000001, 32'h00000002, 0,  2,  1'b0, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 3,  1'b1};
    tbl[9]  = '{1'b0, 2'b11, 12'h30B, 32'h0000FFFF, 32'hFFFFFFFF, 3,  1,  1'b0, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 6,  1'b1};
    tbl[10] = '{1'b0, 2'b01, 12'h30C, 32'h00000077, 32'h00000066, 0,  3,  1'b1, 32'h00000077, 1'b0, 32'h00000000, 1'b0, 3,  1'b1};
    tbl[11] = '{1'b1, 2'b01, 12'h341, 32'h00000080, 32'h00001888, 2,  2,  1'b1, 32'h00000080, 1'b1, 32'h00001888, 1'b0, 5,  1'b1};
    tbl[12] = '{1'b1, 2'b01, 12'h342, 32'h00000005, 32'h00000006, 99, -1, 1'b0, 32'h00000000, 1'b1, 32'h00000000, 1'b0, 16, 1'b1};
    for (int i = 0; i < 13; i++) check_access(i, tbl[i]);

    // Trap and instruction request in the same cycle: trap completes first
    wr_q.delete(); iack_q.delete(); tack_q.delete();
    old_t = ref_mem[12'h341];
    old_i = ref_mem[12'h304];
    rv_delay = 0; flush_at = -1;
    n = cyc;
    t_pend = 1'b1; t_addr = 12'h341; t_wd = 32'h00000008;
    i_pend = 1'b1; i_op = 2'b10; i_addr = 12'h304; i_wd = 32'h00000003;
    run(16);
    i_pend = 1'b0; t_pend = 1'b0;
    chk("arb_wr_cnt", 128'(wr_q.size()), 128'(2));
    chk("arb_tack_cnt", 128'(tack_q.size()), 128'(1));
    chk("arb_iack_cnt", 128'(iack_q.size()), 128'(1));
    if ((wr_q.size() == 2) && (tack_q.size() == 1) && (iack_q.size() == 1)) begin
      chk("arb_t_wr_addr", 128'(wr_q[0].a), 128'(12'h341));
      chk("arb_t_wr_cyc", 128'(wr_q[0].c - n), 128'(2));
      chk("arb_t_wr_data", 128'(wr_q[0].d), 128'(32'h00000008));
      chk("arb_tack_cyc", 128'(tack_q[0].c - n), 128'(3));
      chk("arb_trdata", 128'(tack_q[0].d), 128'(old_t));
      chk("arb_i_wr_addr", 128'(wr_q[1].a), 128'(12'h304));
      chk("arb_i_wr_cyc", 128'(wr_q[1].c - n), 128'(6));
      chk("arb_i_wr_data", 128'(wr_q[1].d), 128'(old_i | 32'h00000003));
      chk("arb_iack_cyc", 128'(iack_q[0].c - n), 128'(7));
      chk("arb_irdata", 128'(iack_q[0].d), 128'(old_i));
    end
    ref_mem[12'h341] = 32'h00000008;
    ref_mem[12'h304] = old_i | 32'h00000003;

    // I_OP=00 is ignored in IDLE
    wr_q.delete(); iack_q.delete(); tack_q.delete();
    n = cyc;
    i_pend = 1'b1; i_op = 2'b00; i_addr = 12'h3F0; i_wd = 32'h12121212;
    run(4);
    i_pend = 1'b0;
    busy_any = 1'b0;
    for (int k = n; k < n + 4; k++) busy_any = busy_any | busy_log[k];
    chk("nop_busy", 128'(busy_any), 128'(0));
    chk("nop_ack", 128'(iack_q.size() + wr_q.size()), 128'(0));

    // Asynchronous reset in the middle of a READ
    wr_q.delete(); iack_q.delete(); tack_q.delete();
    rv_delay = 99;
    i_pend = 1'b1; i_op = 2'b01; i_addr = 12'h3A0; i_wd = 32'h0BAD0BAD;
    run(3);
    chk("mid_read_raddr", 128'(CSR_RADDR), 128'(12'h3A0));
    #2;
    RST_N = 1'b0;
    #1;
    chk("rst_async_outs", outs_s, 128'(0));
    i_pend = 1'b0; I_REQ = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    run(6);
    chk("rst_no_write", 128'(wr_q.size()), 128'(0));
    chk("rst_no_ack", 128'(iack_q.size()), 128'(0));
    chk("rst_idle", 128'(busy_log[cyc - 1]), 128'(0));
    chk("rst_mem_kept", 128'(csr_mem[12'h3A0]), 128'(ref_mem[12'h3A0]));

    // Random accesses against the memory model
    for (int k = 0; k < 40; k++) begin
      rt    = ($urandom_range(0, 3) == 0);
      rop   = rt ? 2'b01 : 2'($urandom_range(1, 3));
      raddr = 12'($urandom_range(1, 4095));
      rwd   = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      r     = $urandom_range(0, 5);
      case (r)
        0:       rdly = 0;
        1:       rdly = 1;
        2:       rdly = TO - 1;
        3:       rdly = TO;
        4:       rdly = 99;
        default: rdly = $urandom_range(0, 6);
      endcase
      rlat = (rdly < TO) ? rdly + 3 : TO + 1;
      rfl  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, rlat) : -1;
      v = model(rt, rop, raddr, rwd, rdly, rfl);
      check_access(100 + k, v);
    end

    chk("csr_mem_final_0x304", 128'(csr_mem[12'h304]), 128'(ref_mem[12'h304]));
    chk("wr_bus_zero_when_idle", 128'(zero_viol), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
